// File: rtl/regfile_arbiter_pkg.sv
// Shared types for the register-file arbiter.
//   state_t : top-level sequencer state (normal arbitration / clearing).
package regfile_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

endpackage

// File: rtl/regfile_arbiter_if.sv
// Requester-side bus of the register-file arbiter.
//   rd_valid/rd_adr -> rd_ready        : per-requester read request/grant
//   wr_valid/wr_adr/wr_data -> wr_ready : per-requester write request/grant
//   rsp_valid/rsp_id/rsp_rdata         : read response, one cycle after grant
// master = requesting units, slave = arbiter.
interface regfile_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int NREQ  = 3
);
  localparam int AW = $clog2(N);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]                rd_valid;
  logic [NREQ-1:0][AW-1:0]        rd_adr;
  logic [NREQ-1:0]                rd_ready;
  logic [NREQ-1:0]                wr_valid;
  logic [NREQ-1:0][AW-1:0]        wr_adr;
  logic [NREQ-1:0][WIDTH-1:0]     wr_data;
  logic [NREQ-1:0]                wr_ready;
  logic                           rsp_valid;
  logic [IW-1:0]                  rsp_id;
  logic [WIDTH-1:0]               rsp_rdata;

  modport master (
    output rd_valid, rd_adr, wr_valid, wr_adr, wr_data,
    input  rd_ready, wr_ready, rsp_valid, rsp_id, rsp_rdata
  );

  modport slave (
    input  rd_valid, rd_adr, wr_valid, wr_adr, wr_data,
    output rd_ready, wr_ready, rsp_valid, rsp_id, rsp_rdata
  );

endinterface

// File: rtl/regfile_arbiter_rr_arbiter.sv
// Round-robin arbiter with its own rotating priority pointer.
//   clk, reset : clock, synchronous active-high reset (pointer -> 0)
//   req        : request vector
//   advance    : commit the current grant (pointer moves past the winner)
//   grant      : one-hot grant, zero when no request
//   grant_idx  : index of the granted requester (0 when none)
module rr_arbiter #(
  parameter  int NREQ = 3,
  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   grant_idx
);

  logic [IW-1:0] ptr;
  int            idx;

  // Walk from the farthest offset back to the pointer so the requester
  // closest to the pointer (in rotating order) is the last one written.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    idx       = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NREQ;
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_idx  = IW'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (advance && |grant) begin
      ptr <= (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + IW'(1);
    end
  end

endmodule

// File: rtl/regfile_arbiter.sv
// Shares one single-read/single-write register file among NREQ requesters.
// Independent round-robin arbitration per port; a clear sequence zeroes all
// N entries through the write port, one per cycle.
//   clk, reset        : clock, synchronous active-high reset
//   bus               : requester bus (slave side), see regfile_arbiter_if
//   clear_req         : start a clear (honoured in IDLE only)
//   busy, clear_done  : clearing in progress / one-cycle completion pulse
//   rf_write_*        : register-file write port
//   rf_read_*         : register-file read port, rf_data_out is combinational
module regfile_arbiter
  import regfile_arb_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int N     = 4,
  parameter  int NREQ  = 3,
  localparam int AW    = $clog2(N),
  localparam int IW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              reset,
  regfile_arbiter_if.slave  bus,
  input  logic              clear_req,
  output logic              busy,
  output logic              clear_done,
  output logic              rf_write_en,
  output logic [AW-1:0]     rf_write_adr,
  output logic [WIDTH-1:0]  rf_data_in,
  output logic              rf_read_en,
  output logic [AW-1:0]     rf_read_adr,
  input  logic [WIDTH-1:0]  rf_data_out
);

  state_t          state, state_nxt;
  logic [AW-1:0]   clr_cnt;
  logic            clr_last;
  logic            clearing;
  logic            hold;

  logic [NREQ-1:0] rd_req, wr_req, rd_grant, wr_grant;
  logic [IW-1:0]   rd_idx, wr_idx;

  logic            rsp_valid_q;
  logic [IW-1:0]   rsp_id_q;
  logic [WIDTH-1:0] rsp_rdata_q;

  assign clearing = (state == ST_CLEAR) && !reset;
  assign clr_last = (clr_cnt == AW'(N - 1));
  // No grants while clearing, and nothing reaches the register file in reset.
  assign hold     = reset || (state == ST_CLEAR);
  assign rd_req   = hold ? '0 : bus.rd_valid;
  assign wr_req   = hold ? '0 : bus.wr_valid;

  rr_arbiter #(.NREQ(NREQ)) u_rd_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (rd_req),
    .advance   (|rd_grant),
    .grant     (rd_grant),
    .grant_idx (rd_idx)
  );

  rr_arbiter #(.NREQ(NREQ)) u_wr_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (wr_req),
    .advance   (|wr_grant),
    .grant     (wr_grant),
    .grant_idx (wr_idx)
  );

  assign bus.rd_ready  = rd_grant;
  assign bus.wr_ready  = wr_grant;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign busy          = clearing;

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (clear_req) state_nxt = ST_CLEAR;
      ST_CLEAR: if (clr_last)  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      clr_cnt     <= '0;
      clear_done  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_rdata_q <= '0;
    end else begin
      state       <= state_nxt;
      clr_cnt     <= (state == ST_CLEAR && !clr_last) ? clr_cnt + AW'(1) : '0;
      // Registered so the pulse lands in the first IDLE cycle, as busy drops.
      clear_done  <= (state == ST_CLEAR) && clr_last;
      rsp_valid_q <= |rd_grant;
      if (|rd_grant) begin
        rsp_id_q    <= rd_idx;
        rsp_rdata_q <= rf_data_out;
      end
    end
  end

  // Write port: the clear sequence owns it outright while clearing.
  always_comb begin
    rf_write_en  = 1'b0;
    rf_write_adr = '0;
    rf_data_in   = '0;
    if (clearing) begin
      rf_write_en  = 1'b1;
      rf_write_adr = clr_cnt;
    end else if (|wr_grant) begin
      rf_write_en  = 1'b1;
      rf_write_adr = bus.wr_adr[wr_idx];
      rf_data_in   = bus.wr_data[wr_idx];
    end
  end

  always_comb begin
    rf_read_en  = 1'b0;
    rf_read_adr = '0;
    if (|rd_grant) begin
      rf_read_en  = 1'b1;
      rf_read_adr = bus.rd_adr[rd_idx];
    end
  end

endmodule

// File: tb/tb_regfile_arbiter.sv
module tb_regfile_arbiter;
  localparam int WIDTH = 32;
  localparam int N     = 4;
  localparam int NREQ  = 3;

  logic              clk;
  logic              reset;
  logic              clear_req;
  logic              busy, clear_done;
  logic              rf_write_en, rf_read_en;
  logic [1:0]        rf_write_adr, rf_read_adr;
  logic [WIDTH-1:0]  rf_data_in, rf_data_out;

  regfile_arbiter_if #(.WIDTH(WIDTH), .N(N), .NREQ(NREQ)) bus ();

  regfile_arbiter #(.WIDTH(WIDTH), .N(N), .NREQ(NREQ)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .clear_req    (clear_req),
    .busy         (busy),
    .clear_done   (clear_done),
    .rf_write_en  (rf_write_en),
    .rf_write_adr (rf_write_adr),
    .rf_data_in   (rf_data_in),
    .rf_read_en   (rf_read_en),
    .rf_read_adr  (rf_read_adr),
    .rf_data_out  (rf_data_out)
  );

  // Register file: combinational read, write at the rising edge.
  logic [WIDTH-1:0] rf_mem [N] = '{default: '0};
  assign rf_data_out = rf_mem[rf_read_adr];
  always @(posedge clk) if (rf_write_en) rf_mem[rf_write_adr] <= rf_data_in;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: expected RF contents, pointers and sequencer as plain ints.
  logic [WIDTH-1:0] ref_mem [N] = '{default: '0};
  int               m_rd_ptr = 0, m_wr_ptr = 0, m_cnt = 0, m_rsp_id = 0;
  bit               m_clr = 0, m_rsp_v = 0, m_done = 0;
  logic [WIDTH-1:0] m_rsp_d = '0;
  logic [NREQ-1:0]  last_rd_ready, last_wr_ready;
  int               order [6];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] v, input int ptr);
    for (int k = 0; k < NREQ; k++)
      if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    return -1;
  endfunction

  // One clock: inputs are already applied; compare at the falling edge,
  // then advance the model on the rising edge.
  task automatic step();
    int rg, wg;
    bit blk;
    logic [NREQ-1:0] erd, ewr;
    @(negedge clk);
    blk = reset || m_clr;
    rg  = blk ? -1 : pick(bus.rd_valid, m_rd_ptr);
    wg  = blk ? -1 : pick(bus.wr_valid, m_wr_ptr);
    erd = '0; ewr = '0;
    if (rg >= 0) erd[rg] = 1'b1;
    if (wg >= 0) ewr[wg] = 1'b1;
    chk("rd_ready", bus.rd_ready, erd);
    chk("wr_ready", bus.wr_ready, ewr);
    if (!reset && m_clr) begin
      chk("wr_en", rf_write_en, 1);
      chk("wr_adr", rf_write_adr, m_cnt);
      chk("wr_data", rf_data_in, 0);
    end else if (wg >= 0) begin
      chk("wr_en", rf_write_en, 1);
      chk("wr_adr", rf_write_adr, bus.wr_adr[wg]);
      chk("wr_data", rf_data_in, bus.wr_data[wg]);
    end else begin
      chk("wr_idle", {rf_write_en, rf_write_adr, rf_data_in}, 0);
    end
    if (rg >= 0) chk("rd_port", {rf_read_en, rf_read_adr}, {1'b1, bus.rd_adr[rg]});
    else         chk("rd_idle", {rf_read_en, rf_read_adr}, 0);
    chk("busy", busy, !reset && m_clr);
    chk("clear_done", clear_done, m_done);
    chk("rsp_valid", bus.rsp_valid, m_rsp_v);
    if (m_rsp_v) begin
      chk("rsp_id", bus.rsp_id, m_rsp_id);
      chk("rsp_rdata", bus.rsp_rdata, m_rsp_d);
    end
    last_rd_ready = bus.rd_ready;
    last_wr_ready = bus.wr_ready;
    @(posedge clk);
    if (reset) begin
      m_rd_ptr = 0; m_wr_ptr = 0; m_clr = 0; m_cnt = 0; m_rsp_v = 0; m_done = 0;
    end else begin
      m_rsp_v = (rg >= 0);
      if (rg >= 0) begin
        m_rsp_id = rg;
        m_rsp_d  = ref_mem[bus.rd_adr[rg]];  // pre-write value, no bypass
        m_rd_ptr = (rg + 1) % NREQ;
      end
      if (wg >= 0) begin
        ref_mem[bus.wr_adr[wg]] = bus.wr_data[wg];
        m_wr_ptr = (wg + 1) % NREQ;
      end
      m_done = 0;
      if (m_clr) begin
        ref_mem[m_cnt] = '0;
        if (m_cnt == N - 1) begin m_clr = 0; m_cnt = 0; m_done = 1; end
        else m_cnt++;
      end else if (clear_req) begin
        m_clr = 1; m_cnt = 0;
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    bus.rd_valid = '0; bus.wr_valid = '0; clear_req = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1; step(); reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    bus.rd_adr = '0; bus.wr_adr = '0; bus.wr_data = '0;
    @(posedge clk); #1;
    step(); step();                       // reset state
    reset = 1'b0;

    // Single requester write then read.
    bus.wr_valid = 3'b010; bus.wr_adr[1] = 2'd2; bus.wr_data[1] = 32'hDEADBEEF;
    step();
    bus.wr_valid = '0; bus.rd_valid = 3'b010; bus.rd_adr[1] = 2'd2;
    step();
    bus.rd_valid = '0;
    chk("single_rsp", {bus.rsp_valid, bus.rsp_id, bus.rsp_rdata}, {1'b1, 2'd1, 32'hDEADBEEF});
    step();

    // Write fairness from reset.
    do_reset();
    bus.wr_valid = 3'b111;
    for (int i = 0; i < NREQ; i++) begin bus.wr_adr[i] = 2'(i); bus.wr_data[i] = $urandom; end
    for (int c = 0; c < 6; c++) begin
      step();
      order[c] = -1;
      for (int i = 0; i < NREQ; i++)
        if (last_wr_ready[i]) begin order[c] = i; bus.wr_data[i] = $urandom; end
    end
    bus.wr_valid = '0;
    for (int c = 0; c < 6; c++) chk($sformatf("fair_%0d", c), 64'(order[c]), 64'(c % 3));

    // Simultaneous read/write to the same address.
    bus.wr_valid = 3'b001; bus.wr_adr[0] = 2'd3; bus.wr_data[0] = 32'h5;
    step();
    bus.wr_valid = 3'b010; bus.wr_adr[1] = 2'd3; bus.wr_data[1] = 32'h9;
    bus.rd_valid = 3'b001; bus.rd_adr[0] = 2'd3;
    step();
    idle_inputs();
    chk("rw_old", bus.rsp_rdata, 32'h5);
    bus.rd_valid = 3'b001;
    step();
    bus.rd_valid = '0;
    chk("rw_new", bus.rsp_rdata, 32'h9);

    // Fill, then clear with requests pending throughout.
    for (int a = 0; a < N; a++) begin
      bus.wr_valid = 3'b001; bus.wr_adr[0] = 2'(a); bus.wr_data[0] = 32'h100 + 32'(a);
      step();
    end
    clear_req = 1'b1;
    bus.rd_valid = 3'b001; bus.rd_adr[0] = 2'd1;   // in flight at clear entry
    bus.wr_valid = 3'b010; bus.wr_adr[1] = 2'd0; bus.wr_data[1] = 32'hABCD;
    step();
    bus.wr_valid = '0;
    bus.rd_valid = 3'b110; bus.rd_adr[1] = 2'd2; bus.rd_adr[2] = 2'd3;
    for (int c = 0; c < N; c++) begin
      if (c == N - 1) clear_req = 1'b0;           // held high until here: ignored
      step();
    end
    chk("clear_done_pulse", {busy, clear_done}, 2'b01);
    for (int c = 0; c < 2; c++) begin
      step();
      bus.rd_valid = bus.rd_valid & ~last_rd_ready;
    end
    bus.rd_valid = '0;
    for (int a = 0; a < N; a++) begin
      bus.rd_valid = 3'b001; bus.rd_adr[0] = 2'(a);
      step();
      chk($sformatf("cleared_%0d", a), {bus.rsp_valid, bus.rsp_rdata}, {1'b1, 32'h0});
    end
    bus.rd_valid = '0;
    step();
    chk("done_once", clear_done, 1'b0);

    // Reset in the middle of a clear.
    for (int a = 0; a < N; a++) begin
      bus.wr_valid = 3'b001; bus.wr_adr[0] = 2'(a); bus.wr_data[0] = $urandom;
      step();
    end
    clear_req = 1'b1;
    bus.wr_valid = 3'b010; bus.rd_valid = 3'b010; bus.rd_adr[1] = 2'd2;
    step();
    idle_inputs();
    step(); step();                               // clr_cnt 0, 1
    reset = 1'b1; bus.rd_valid = 3'b001;
    step();                                       // clr_cnt 2, reset
    reset = 1'b0; bus.rd_valid = '0;
    chk("rst_mid", {busy, clear_done, bus.rsp_valid}, 3'b000);
    bus.wr_valid = 3'b111; bus.rd_valid = 3'b111;
    step();
    chk("rst_ptrs", {last_rd_ready, last_wr_ready}, {3'b001, 3'b001});
    idle_inputs();

    // Pointer hold across an idle cycle.
    do_reset();
    bus.wr_valid = 3'b100; step();
    bus.wr_valid = 3'b000; step();
    bus.wr_valid = 3'b101; step();
    chk("ptr_hold", last_wr_ready, 3'b001);
    bus.wr_valid = 3'b100; step();
    idle_inputs();

    // Random traffic with requesters holding requests until granted.
    for (int c = 0; c < 400; c++) begin
      clear_req = ($urandom_range(0, 39) == 0);
      for (int i = 0; i < NREQ; i++) begin
        if (last_rd_ready[i]) bus.rd_valid[i] = 1'b0;
        if (last_wr_ready[i]) bus.wr_valid[i] = 1'b0;
        if (!bus.rd_valid[i] && $urandom_range(0, 2) == 0) begin
          bus.rd_valid[i] = 1'b1; bus.rd_adr[i] = 2'($urandom_range(0, N - 1));
        end
        if (!bus.wr_valid[i] && $urandom_range(0, 2) == 0) begin
          bus.wr_valid[i] = 1'b1; bus.wr_adr[i] = 2'($urandom_range(0, N - 1));
          bus.wr_data[i] = $urandom;
        end
      end
      step();
    end
    idle_inputs();
    for (int c = 0; c < N + 2; c++) step();
    chk("final_idle", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
